srt_div_arbiter: RTL and testbench
==================================

# srt_div_arbiter

Round-robin arbiter and sequencer that shares one `Radix4SRTDivider` instance among `NUM_REQ` requesters. It accepts operand requests over valid/ready handshakes and drives the divider's reset/start protocol, holding operands stable until `done`. It then returns each result, tagged with the requester index, over a single valid/ready response channel. It sits between the integer-pipeline issue ports and the divider datapath.

## Interface
- `N`, 32: operand width; must equal the divider's `N`.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: response tag width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept, at most one bit high.
- `req_x` in `NUM_REQ*N`: dividends, requester i at `[i*N +: N]`.
- `req_y` in `NUM_REQ*N`: divisors, same packing.
- `req_signed` in `NUM_REQ`: signed-operation flag per requester.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out `ID_W`: index of the requester served.
- `rsp_q` out N: quotient.
- `rsp_r` out N: remainder.
- `rsp_dbz` out 1: divide-by-zero flag.
- `rsp_timeout` out 1: watchdog expired; `q`/`r` invalid.
- `busy` out 1: high in any state other than IDLE.
- `div_rst` out 1: divider reset.
- `div_start` out 1: divider start.
- `div_signed` out 1: divider signedInput.
- `div_x` out N: divider x.
- `div_y` out N: divider y.
- `div_q` in N: divider q.
- `div_r` in N: divider r.
- `div_done` in 1: divider done.
- `div_dbz` in 1: divider divByZeroEx.

## Operation
- States: IDLE, CLR, LAUNCH, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, grant the first valid index after `last_grant`, wrapping modulo `NUM_REQ`.
  - Drive `req_ready[g]` high combinationally for the granted index only.
  - On the handshake, capture `x`, `y`, `signed` and `g` into holding registers, set `last_grant <= g`, go to CLR.
  - If no request is valid, `req_ready` is 0.
- **CLR**: `div_rst = 1` for exactly one cycle, which returns the divider to its RESET state. Go to LAUNCH.
- **LAUNCH**: `div_start = 1` for exactly one cycle. Go to WAIT and clear the watchdog.
- **WAIT**
  - On the first cycle with `div_done = 1`, capture `div_q`, `div_r` and `div_dbz`, set `rsp_timeout = 0`, go to RESP.
  - The watchdog counts WAIT cycles. If it reaches `ceil(N/2)+4` without `div_done`, set `rsp_timeout = 1`, `rsp_q = rsp_r = 0`, `rsp_dbz = 0`, go to RESP.
- **RESP**
  - `rsp_valid = 1`.
  - All `rsp_*` fields stay stable until `rsp_ready`.
  - On the handshake, go to IDLE.
  - No new grant is issued while in RESP.
- **Operand hold**: `div_x`, `div_y` and `div_signed` are driven from the holding registers continuously from CLR through RESP. The divider reads its inputs combinationally in its START and final RUN cycles.
- `div_rst = rst | (state == CLR)`.
- Results pass through unmodified. The controller does no sign or remainder correction.

## Timing
- **Reset values**:
  - state IDLE.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - `rsp_valid`, `rsp_id`, `rsp_q`, `rsp_r`, `rsp_dbz`, `rsp_timeout`, `busy`, `div_start`, `req_ready` all 0.
  - holding registers 0.
  - `div_rst = 1` while `rst` is high.
- **Cycle numbering**: request handshake is cycle 0, CLR is cycle 1, LAUNCH is cycle 2, the divider is in START in cycle 3.
- **Normal divide** (`y != 0`, `|y| != 1`): divider is in RUN for cycles 4..4+ceil(N/2), `div_done` is seen in cycle 5+ceil(N/2), and `rsp_valid` rises in cycle 6+ceil(N/2). For N=32, `rsp_valid` rises in cycle 22.
- **Fast path** (`y == 0` or `|y| == 1`): `div_done` is seen in cycle 4 and `rsp_valid` rises in cycle 5.
- **Throughput**: the earliest next grant is the cycle after the RESP handshake. One operation is in flight at a time.
- A request dropped before its handshake is never served. The arbiter re-evaluates every IDLE cycle.
- **Reset mid-operation**: go to IDLE in the next cycle and drop `rsp_valid`. The in-flight operation produces no response.
- **`rst` and `rsp_ready` in the same cycle**: reset wins.

## Test plan
- **Single unsigned request**: req0 with x=100, y=7, unsigned -> `rsp_id=0`, `q=14`, `r=2`, `rsp_valid` in cycle 22 (N=32).
- **Signed request**: req2 with x=0xFFFFFF9C (-100), y=7, signed -> `rsp_id=2`, `q=0xFFFFFFF2`, `r=2`.
- **Fast paths**:
  - x=55, y=0 -> `rsp_dbz=1`, `q=0`, `r=0`, `rsp_valid` in cycle 5.
  - x=55, y=1 -> `q=55`, `rsp_dbz=0`, `rsp_valid` in cycle 5.
- **Contention**: all four requesters valid continuously -> service order 0,1,2,3,0. Exactly one `req_ready` bit per grant. `div_rst` pulses before every `div_start`.
- **Backpressure**: `rsp_ready` held low for 10 cycles in RESP -> `rsp_*` stable, no `req_ready`, `div_x`/`div_y` unchanged. Then `rsp_ready=1` -> next grant in the following cycle.
- **Reset and watchdog**:
  - `rst` asserted in cycle 10 of a divide -> idle outputs next cycle, no response.
  - Divider model with `div_done` stuck at 0 -> `rsp_timeout=1` after 20 WAIT cycles.

Source files
------------

// File: rtl/srt_div_arbiter_if.sv
// Bundle of the requester, response and divider-side signals of srt_div_arbiter.
//   req_*      : per-requester valid/ready operand channels (operands packed i*N +: N)
//   rsp_*      : single tagged result channel (valid/ready)
//   busy       : arbiter not idle
//   div_*      : connection to the shared Radix4SRTDivider instance
// Modport slave is the arbiter's view; master is the surrounding environment's view.
interface srt_div_arbiter_if #(
  parameter int unsigned N       = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_x;
  logic [NUM_REQ*N-1:0] req_y;
  logic [NUM_REQ-1:0]   req_signed;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [N-1:0]         rsp_q;
  logic [N-1:0]         rsp_r;
  logic                 rsp_dbz;
  logic                 rsp_timeout;
  logic                 busy;

  logic                 div_rst;
  logic                 div_start;
  logic                 div_signed;
  logic [N-1:0]         div_x;
  logic [N-1:0]         div_y;
  logic [N-1:0]         div_q;
  logic [N-1:0]         div_r;
  logic                 div_done;
  logic                 div_dbz;

  modport slave (
    input  req_valid, req_x, req_y, req_signed, rsp_ready,
           div_q, div_r, div_done, div_dbz,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_timeout, busy,
           div_rst, div_start, div_signed, div_x, div_y
  );

  modport master (
    output req_valid, req_x, req_y, req_signed, rsp_ready,
           div_q, div_r, div_done, div_dbz,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_timeout, busy,
           div_rst, div_start, div_signed, div_x, div_y
  );
endinterface

// File: rtl/srt_div_arbiter.sv
// Round-robin arbiter/sequencer sharing one Radix4SRTDivider among NUM_REQ requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : srt_div_arbiter_if.slave (request channels, response channel, divider port)
// Flow: IDLE (grant) -> CLR (divider reset) -> LAUNCH (start) -> WAIT (done or watchdog)
// -> RESP (hold result until accepted). One operation in flight at a time.
module srt_div_arbiter #(
  parameter int unsigned N       = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst,
  srt_div_arbiter_if.slave  bus
);
  localparam int unsigned WdLimit = (N + 1) / 2 + 4;
  localparam int unsigned WdW     = $clog2(WdLimit + 1);
  localparam int unsigned SumW    = ID_W + 1;
  localparam logic [SumW-1:0] NumReqS = SumW'(NUM_REQ);

  typedef enum logic [2:0] {StIdle, StClr, StLaunch, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [N-1:0]    x_q, x_d, y_q, y_d;
  logic            sgn_q, sgn_d;
  logic [N-1:0]    q_q, q_d, r_q, r_d;
  logic            dbz_q, dbz_d, tmo_q, tmo_d;
  logic [WdW-1:0]  wd_q, wd_d;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic [SumW-1:0] sum;
  logic            hs;

  logic [N-1:0] rx [NUM_REQ];
  logic [N-1:0] ry [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign rx[gi] = bus.req_x[gi*N +: N];
    assign ry[gi] = bus.req_y[gi*N +: N];
  end

  // First valid requester strictly after last_q, wrapping; last_q itself is checked last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      sum = {1'b0, last_q} + SumW'(k);
      if (sum >= NumReqS) sum = sum - NumReqS;
      if (!gnt_vld && bus.req_valid[sum[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = sum[ID_W-1:0];
      end
    end
  end

  assign hs = (state_q == StIdle) && gnt_vld && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    sgn_d   = sgn_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    tmo_d   = tmo_q;
    wd_d    = wd_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          x_d     = rx[gnt_idx];
          y_d     = ry[gnt_idx];
          sgn_d   = bus.req_signed[gnt_idx];
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = StClr;
        end
      end
      StClr:    state_d = StLaunch;
      StLaunch: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.div_done) begin
          q_d     = bus.div_q;
          r_d     = bus.div_r;
          dbz_d   = bus.div_dbz;
          tmo_d   = 1'b0;
          state_d = StResp;
        end else if (wd_q == WdW'(WdLimit - 1)) begin
          // Divider never signalled done: report a timeout with zeroed results.
          q_d     = '0;
          r_d     = '0;
          dbz_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = StResp;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sgn_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      tmo_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sgn_q   <= sgn_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      tmo_q   <= tmo_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.rsp_valid   = (state_q == StResp);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_q       = q_q;
  assign bus.rsp_r       = r_q;
  assign bus.rsp_dbz     = dbz_q;
  assign bus.rsp_timeout = tmo_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.div_rst     = rst | (state_q == StClr);
  assign bus.div_start   = !rst && (state_q == StLaunch);
  // Operands stay on the divider inputs from CLR through RESP; the divider samples them late.
  assign bus.div_x       = x_q;
  assign bus.div_y       = y_q;
  assign bus.div_signed  = sgn_q;
endmodule

// File: tb/tb_srt_div_arbiter.sv
module tb_srt_div_arbiter;
  localparam int unsigned N       = 32;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam logic [7:0]  RunCyc  = 8'((N + 1) / 2 + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  srt_div_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  srt_div_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0] tx [NUM_REQ];
  logic [N-1:0] ty [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
    assign bus.req_x[gi*N +: N] = tx[gi];
    assign bus.req_y[gi*N +: N] = ty[gi];
  end

  // Behavioural divider: done one cycle after START on the fast path, else after RUN.
  logic       stuck = 1'b0;
  logic       dact;
  logic [7:0] dcnt;
  logic       fast;
  logic [N-1:0] m_ax, m_ay, m_uq, m_ur;
  always @(posedge clk) begin
    if (bus.div_rst) begin
      dact <= 1'b0;
      dcnt <= 8'd0;
    end else if (bus.div_start) begin
      dact <= 1'b1;
      dcnt <= 8'd0;
    end else if (dact && dcnt != 8'hFF) begin
      dcnt <= dcnt + 8'd1;
    end
  end
  always_comb begin
    fast = (bus.div_y == '0) || (bus.div_y == N'(1)) || (bus.div_signed && bus.div_y == '1);
    m_ax = (bus.div_signed && bus.div_x[N-1]) ? -bus.div_x : bus.div_x;
    m_ay = (bus.div_signed && bus.div_y[N-1]) ? -bus.div_y : bus.div_y;
    m_uq = (m_ay == '0) ? '0 : m_ax / m_ay;
    m_ur = (m_ay == '0) ? '0 : m_ax % m_ay;
    bus.div_q    = (bus.div_signed && (bus.div_x[N-1] ^ bus.div_y[N-1])) ? -m_uq : m_uq;
    bus.div_r    = m_ur;
    bus.div_dbz  = (bus.div_y == '0);
    bus.div_done = dact && !stuck && (fast ? (dcnt >= 8'd1) : (dcnt >= RunCyc));
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic issue(input logic [ID_W-1:0] id, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic s);
    tx[id]             = x;
    ty[id]             = y;
    bus.req_signed[id] = s;
    bus.req_valid[id]  = 1'b1;
  endtask

  task automatic wait_grant(output int g, output int waits);
    g     = -1;
    waits = 0;
    for (int i = 0; i < 50 && g < 0; i++) begin
      @(negedge clk);
      waits++;
      if (bus.req_ready != '0) begin
        chk("one_hot_ready", $countones(bus.req_ready), 1);
        g = $clog2(bus.req_ready);
      end
    end
    if (g < 0) chk("grant_wait_expired", 0, 1);
  endtask

  // Cycle 1 is the first negedge after the request handshake edge.
  task automatic wait_rsp(output int lat, output int seq_ok);
    lat    = 0;
    seq_ok = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !(bus.div_rst && !bus.div_start)) seq_ok = 0;
      if (lat == 2 && !(bus.div_start && !bus.div_rst)) seq_ok = 0;
      if (lat > 2 && (bus.div_start || bus.div_rst)) seq_ok = 0;
      if (bus.rsp_valid) break;
    end
    if (!bus.rsp_valid) begin
      chk("rsp_wait_expired", 0, 1);
      lat = -1;
    end
  endtask

  typedef struct {
    logic [ID_W-1:0] id;
    logic [N-1:0]    x;
    logic [N-1:0]    y;
    logic            s;
    logic [N-1:0]    q;
    logic [N-1:0]    r;
    logic            dbz;
    int              lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int g, w, lat, ok, flag;
    logic [N-1:0] sq, sr, sx, sy;
    logic [ID_W-1:0] sid;

    vecs[0] = '{2'd0, 32'd100,        32'd7,        1'b0, 32'd14,         32'd2,  1'b0, 22};
    vecs[1] = '{2'd2, 32'hFFFFFF9C,   32'd7,        1'b1, 32'hFFFFFFF2,   32'd2,  1'b0, 22};
    vecs[2] = '{2'd1, 32'd55,         32'd0,        1'b0, 32'd0,          32'd0,  1'b1, 5};
    vecs[3] = '{2'd3, 32'd55,         32'd1,        1'b0, 32'd55,         32'd0,  1'b0, 5};
    vecs[4] = '{2'd1, 32'd20,         32'hFFFFFFFF, 1'b1, 32'hFFFFFFEC,   32'd0,  1'b0, 5};
    vecs[5] = '{2'd0, 32'd1000,       32'd33,       1'b0, 32'd30,         32'd10, 1'b0, 22};
    vecs[6] = '{2'd3, 32'hFFFFFFFF,   32'd2,        1'b0, 32'h7FFFFFFF,   32'd1,  1'b0, 22};

    bus.req_valid  = '0;
    bus.req_signed = '0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      tx[i] = '0;
      ty[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_div_rst", int'(bus.div_rst), 1);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_div_start", int'(bus.div_start), 0);
    chk("rst_div_rst_low", int'(bus.div_rst), 0);
    chk("rst_rsp_fields", int'(bus.rsp_q | bus.rsp_r), 0);
    chk("rst_rsp_flags", int'({bus.rsp_id, bus.rsp_dbz, bus.rsp_timeout}), 0);
    chk("rst_hold_regs", int'(bus.div_x | bus.div_y), 0);
    @(posedge clk);
    #1;

    // Table-driven single operations
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].s);
      wait_grant(g, w);
      chk("vec_grant", g, int'(vecs[i].id));
      @(posedge clk);
      #1 bus.req_valid = '0;
      wait_rsp(lat, ok);
      chk("vec_latency", lat, vecs[i].lat);
      chk("vec_rst_start_seq", ok, 1);
      chk("vec_id", int'(bus.rsp_id), int'(vecs[i].id));
      chk("vec_q", int'(bus.rsp_q), int'(vecs[i].q));
      chk("vec_r", int'(bus.rsp_r), int'(vecs[i].r));
      chk("vec_dbz", int'(bus.rsp_dbz), int'(vecs[i].dbz));
      chk("vec_timeout", int'(bus.rsp_timeout), 0);
      @(posedge clk);
      #1;
      chk("vec_rsp_dropped", int'(bus.rsp_valid), 0);
    end

    // Contention: all four held valid, last grant was 3
    for (int i = 0; i < int'(NUM_REQ); i++) issue(ID_W'(i), N'(10 * (i + 1)), 32'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, w);
      chk("rr_order", g, k % 4);
      if (k > 0) chk("rr_back_to_back", w, 1);
      @(posedge clk);
      #1;
      wait_rsp(lat, ok);
      chk("rr_rst_start_seq", ok, 1);
      chk("rr_id", int'(bus.rsp_id), k % 4);
      chk("rr_q", int'(bus.rsp_q), (10 * (k % 4 + 1)) / 3);
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;

    // Backpressure: last grant 0, requesters 1 and 3 pending
    bus.rsp_ready = 1'b0;
    issue(2'd1, 32'd200, 32'd9, 1'b0);
    issue(2'd3, 32'd81, 32'd9, 1'b0);
    wait_grant(g, w);
    chk("bp_grant", g, 1);
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    wait_rsp(lat, ok);
    chk("bp_latency", lat, 22);
    chk("bp_q", int'(bus.rsp_q), 22);
    chk("bp_r", int'(bus.rsp_r), 2);
    sq  = bus.rsp_q;
    sr  = bus.rsp_r;
    sid = bus.rsp_id;
    sx  = bus.div_x;
    sy  = bus.div_y;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      flag = int'(bus.rsp_valid && bus.rsp_q == sq && bus.rsp_r == sr && bus.rsp_id == sid &&
                  bus.div_x == sx && bus.div_y == sy && bus.req_ready == '0);
      chk("bp_stable", flag, 1);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    wait_grant(g, w);
    chk("bp_next_grant", g, 3);
    chk("bp_next_grant_delay", w, 1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_rsp(lat, ok);
    chk("bp2_id", int'(bus.rsp_id), 3);
    chk("bp2_q", int'(bus.rsp_q), 9);
    chk("bp2_r", int'(bus.rsp_r), 0);
    @(posedge clk);
    #1;

    // Reset in cycle 10 of a normal divide
    issue(2'd0, 32'd1000, 32'd33, 1'b0);
    wait_grant(g, w);
    chk("mr_grant", g, 0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mr_div_rst", int'(bus.div_rst), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_busy", int'(bus.busy), 0);
    chk("mr_idle_outs", int'({bus.rsp_valid, bus.div_start, bus.req_ready}), 0);
    flag = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) flag = 1;
    end
    chk("mr_no_response", flag, 0);
    @(posedge clk);
    #1;

    // Watchdog: divider never reports done; last grant is 3 after reset
    stuck = 1'b1;
    issue(2'd2, 32'd5, 32'd3, 1'b0);
    wait_grant(g, w);
    chk("wd_grant", g, 2);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_rsp(lat, ok);
    chk("wd_latency", lat, 23);
    chk("wd_timeout", int'(bus.rsp_timeout), 1);
    chk("wd_zero_fields", int'(bus.rsp_q | bus.rsp_r), 0);
    chk("wd_dbz", int'(bus.rsp_dbz), 0);
    chk("wd_id", int'(bus.rsp_id), 2);
    @(posedge clk);
    #1 stuck = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
